i2c_target: RTL

I2C target (responder) for the bus that the `sclk`/`sda` initiator drives. It oversamples `sclk` and `sda` on the system clock and detects START, repeated START and STOP. It matches a 7-bit address, ACKs, and then either receives write bytes into a one-byte output register with a valid pulse, or shifts out bytes supplied by the core. It drives `sda` open-drain only: it pulls low or releases, never drives high.

---
 rtl/i2c_pkg.sv | 23 ++
 rtl/i2c_line_sync.sv | 34 +++
 rtl/i2c_target.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target.
package i2c_pkg;

   // Protocol phases of the target, from bus idle through address, data and ACK slots.
   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      WR_DATA,
      WR_ACK,
      RD_DATA,
      RD_ACK,
      IGNORE
   } i2c_state_e;

   // Level seen on sda in an acknowledge slot.
   localparam logic I2C_ACK     = 1'b0;
   localparam logic I2C_NACK    = 1'b1;

   // Value of the R/W bit that follows the 7-bit address for a read.
   localparam logic I2C_RW_READ = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizer for one bus line, plus a registered edge-detect stage.
// level/rise/fall are all produced by the same stage, so they are mutually
// aligned: when rise is high, level is already 1 and the previous sample was 0.
// Everything resets to the idle (pulled-up) level of 1.
module i2c_line_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic line,
   output logic level,
   output logic rise,
   output logic fall
);

   logic meta;
   logic sync;

   // Synchronize the asynchronous line and register its edges.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta  <= 1'b1;
         sync  <= 1'b1;
         level <= 1'b1;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         meta  <= line;
         sync  <= meta;
         level <= sync;
         rise  <= sync & ~level;
         fall  <= ~sync & level;
      end
   end

endmodule

// File: rtl/i2c_target.sv
// I2C target: oversampled START/STOP detection, 7-bit address match, ACKed
// multi-byte writes into rx_data and core-supplied bytes returned on reads.
// sda is only ever pulled low (sda_oe=1) or released (sda_oe=0).
//
// Core-side strobes: rx_valid and tx_load are single-clk pulses with no
// back-pressure. rx_data is valid in the cycle rx_valid is high and holds until
// the next byte. tx_data must be stable for at least one clk before the cycle
// it is captured; tx_load is asserted in the cycle that follows that capture
// edge, so the core may advance to its next byte on seeing tx_load.
module i2c_target
   import i2c_pkg::*;
#(
   parameter logic [6:0] ADDRESS = 7'h27
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sclk,
   input  logic       sda_i,
   output logic       sda_oe,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_load,
   output logic       busy
);

   logic scl_lvl, scl_rise, scl_fall;
   logic sda_lvl, sda_rise, sda_fall;

   i2c_line_sync u_scl_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .line  (sclk),
      .level (scl_lvl),
      .rise  (scl_rise),
      .fall  (scl_fall)
   );

   i2c_line_sync u_sda_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .line  (sda_i),
      .level (sda_lvl),
      .rise  (sda_rise),
      .fall  (sda_fall)
   );

   // An sda edge only counts as START/STOP when sclk was high in both samples;
   // an sclk edge in the same cycle makes it an ordinary data change.
   logic start_det;
   logic stop_det;
   assign start_det = sda_fall & scl_lvl & ~scl_rise;
   assign stop_det  = sda_rise & scl_lvl & ~scl_rise;

   i2c_state_e state, state_d;
   logic [3:0] bit_cnt, cnt_d;
   logic [7:0] shreg, shreg_d;
   logic       rw_q, rw_d;
   logic       sda_oe_d;
   logic [7:0] rx_data_d;
   logic       rx_valid_d;
   logic       tx_load_d;
   logic       busy_d;

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         bit_cnt  <= 4'd0;
         shreg    <= 8'h00;
         rw_q     <= 1'b0;
         sda_oe   <= 1'b0;
         rx_data  <= 8'h00;
         rx_valid <= 1'b0;
         tx_load  <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_d;
         bit_cnt  <= cnt_d;
         shreg    <= shreg_d;
         rw_q     <= rw_d;
         sda_oe   <= sda_oe_d;
         rx_data  <= rx_data_d;
         rx_valid <= rx_valid_d;
         tx_load  <= tx_load_d;
         busy     <= busy_d;
      end
   end

   // Next-state and output logic; STOP and START override every state.
   always_comb begin
      state_d    = state;
      cnt_d      = bit_cnt;
      shreg_d    = shreg;
      rw_d       = rw_q;
      sda_oe_d   = sda_oe;
      rx_data_d  = rx_data;
      rx_valid_d = 1'b0;
      tx_load_d  = 1'b0;
      busy_d     = busy;

      if (stop_det) begin
         state_d  = IDLE;
         sda_oe_d = 1'b0;
         busy_d   = 1'b0;
         cnt_d    = 4'd0;
      end else if (start_det) begin
         state_d  = ADDR;
         sda_oe_d = 1'b0;
         busy_d   = 1'b0;
         cnt_d    = 4'd0;
      end else begin
         case (state)
            IDLE: begin
               sda_oe_d = 1'b0;
            end
            ADDR: begin
               if (scl_rise) begin
                  shreg_d = {shreg[6:0], sda_lvl};
                  cnt_d   = bit_cnt + 4'd1;
               end else if (scl_fall && bit_cnt == 4'd8) begin
                  cnt_d = 4'd0;
                  if (shreg[7:1] == ADDRESS) begin
                     state_d  = ADDR_ACK;
                     rw_d     = shreg[0];
                     sda_oe_d = 1'b1;
                     busy_d   = 1'b1;
                  end else begin
                     state_d  = IGNORE;
                     sda_oe_d = 1'b0;
                  end
               end
            end
            ADDR_ACK: begin
               if (scl_fall) begin
                  cnt_d = 4'd0;
                  if (rw_q == I2C_RW_READ) begin
                     state_d   = RD_DATA;
                     tx_load_d = 1'b1;
                     shreg_d   = tx_data;
                     sda_oe_d  = ~tx_data[7];
                  end else begin
                     state_d  = WR_DATA;
                     sda_oe_d = 1'b0;
                  end
               end
            end
            WR_DATA: begin
               if (scl_rise) begin
                  shreg_d = {shreg[6:0], sda_lvl};
                  cnt_d   = bit_cnt + 4'd1;
                  if (bit_cnt == 4'd7) begin
                     rx_data_d  = {shreg[6:0], sda_lvl};
                     rx_valid_d = 1'b1;
                  end
               end else if (scl_fall && bit_cnt == 4'd8) begin
                  state_d  = WR_ACK;
                  cnt_d    = 4'd0;
                  sda_oe_d = 1'b1;
               end
            end
            WR_ACK: begin
               if (scl_fall) begin
                  state_d  = WR_DATA;
                  sda_oe_d = 1'b0;
               end
            end
            RD_DATA: begin
               // Bit 7 went out when the byte was loaded; each fall presents
               // the next bit, and the fall after bit 0 hands sda back.
               if (scl_fall) begin
                  if (bit_cnt == 4'd7) begin
                     state_d  = RD_ACK;
                     cnt_d    = 4'd0;
                     sda_oe_d = 1'b0;
                  end else begin
                     shreg_d  = {shreg[6:0], 1'b0};
                     sda_oe_d = ~shreg[6];
                     cnt_d    = bit_cnt + 4'd1;
                  end
               end
            end
            RD_ACK: begin
               if (scl_rise && sda_lvl == I2C_NACK) begin
                  state_d  = IGNORE;
                  sda_oe_d = 1'b0;
               end else if (scl_fall) begin
                  state_d   = RD_DATA;
                  cnt_d     = 4'd0;
                  tx_load_d = 1'b1;
                  shreg_d   = tx_data;
                  sda_oe_d  = ~tx_data[7];
               end
            end
            IGNORE: begin
               sda_oe_d = 1'b0;
            end
            default: begin
               state_d  = IDLE;
               sda_oe_d = 1'b0;
            end
         endcase
      end
   end

endmodule
